// File: rtl/e203_nice_macc_if.sv
// NICE request/response channel bundle.
// master = core side, slave = coprocessor side.
interface e203_nice_macc_if;
  logic        nice_req_valid;
  logic        nice_req_ready;
  logic [31:0] nice_req_instr;
  logic [31:0] nice_req_rs1;
  logic [31:0] nice_req_rs2;
  logic        nice_rsp_valid;
  logic        nice_rsp_ready;
  logic [31:0] nice_rsp_rdat;
  logic        nice_rsp_err;

  modport master (
    output nice_req_valid,
    input  nice_req_ready,
    output nice_req_instr,
    output nice_req_rs1,
    output nice_req_rs2,
    input  nice_rsp_valid,
    output nice_rsp_ready,
    input  nice_rsp_rdat,
    input  nice_rsp_err
  );

  modport slave (
    input  nice_req_valid,
    output nice_req_ready,
    input  nice_req_instr,
    input  nice_req_rs1,
    input  nice_req_rs2,
    output nice_rsp_valid,
    input  nice_rsp_ready,
    output nice_rsp_rdat,
    output nice_rsp_err
  );
endinterface

// File: rtl/e203_nice_macc_core.sv
// NICE coprocessor: 32-bit accumulator with
// shift-add MACC and single-cycle acc ops.
module e203_nice_macc_core #(
  parameter logic [6:0] OPCODE     = 7'b1111011,
  parameter int         MUL_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  e203_nice_macc_if.slave    nice,
  output logic               nice_active
);

  localparam int CW = (MUL_CYCLES > 1) ?
                      $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RSP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_acc;
  logic [31:0] r_prod;
  logic [31:0] r_mcand;
  logic [31:0] r_mplr;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_rdat;
  logic        r_err;

  logic        w_req_hs;
  logic        w_rsp_hs;
  logic        w_legal;
  logic [6:0]  w_f7;
  logic        w_macc;
  logic        w_clr;
  logic        w_set;
  logic        w_rd;
  logic        w_last;
  logic [31:0] w_prod_nxt;
  logic [31:0] w_acc_macc;
  logic        w_unused_instr;

  assign w_f7    = nice.nice_req_instr[31:25];
  assign w_legal = nice.nice_req_instr[6:0] == OPCODE;
  assign w_macc  = w_legal & (w_f7 == 7'h01);
  assign w_clr   = w_legal & (w_f7 == 7'h02);
  assign w_set   = w_legal & (w_f7 == 7'h03);
  assign w_rd    = w_legal & (w_f7 == 7'h04);
  assign w_unused_instr = ^nice.nice_req_instr[24:7];

  assign w_req_hs = nice.nice_req_valid &
                    (r_state == S_IDLE);
  assign w_rsp_hs = (r_state == S_RSP) &
                    nice.nice_rsp_ready;
  assign w_last   = r_cnt == LAST;

  assign w_prod_nxt = r_prod +
                      (r_mplr[0] ? r_mcand : 32'd0);
  assign w_acc_macc = r_acc + w_prod_nxt;

  assign nice.nice_req_ready = r_state == S_IDLE;
  assign nice.nice_rsp_valid = r_state == S_RSP;
  assign nice.nice_rsp_rdat  = r_rdat;
  assign nice.nice_rsp_err   = r_err;
  assign nice_active         = r_state != S_IDLE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: MACC detours through BUSY
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_req_hs)
        w_state_nxt = w_macc ? S_BUSY : S_RSP;
      S_BUSY: if (w_last)
        w_state_nxt = S_RSP;
      S_RSP: if (w_rsp_hs)
        w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, multiplier and response datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_rdat  <= '0;
      r_err   <= 1'b0;
    end else if (w_req_hs) begin
      r_err <= ~(w_macc | w_clr | w_set | w_rd);
      unique case (1'b1)
        w_macc: begin
          r_prod  <= '0;
          r_mcand <= nice.nice_req_rs1;
          r_mplr  <= nice.nice_req_rs2;
          r_cnt   <= '0;
        end
        w_clr: begin
          r_rdat <= r_acc;
          r_acc  <= '0;
        end
        w_set: begin
          r_rdat <= r_acc;
          r_acc  <= nice.nice_req_rs1;
        end
        w_rd: r_rdat <= r_acc;
        default: r_rdat <= '0;
      endcase
    end else if (r_state == S_BUSY) begin
      r_prod  <= w_prod_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_acc  <= w_acc_macc;
        r_rdat <= w_acc_macc;
      end
    end
  end

endmodule

// File: tb/tb_e203_nice_macc_core.sv
// Bench for e203_nice_macc_core: directed table,
// random ops vs. arithmetic model, corner sequences.
module tb_e203_nice_macc_core;

  localparam logic [6:0] OPC = 7'b1111011;

  logic clk = 1'b0;
  logic rst_n;
  logic nice_active;
  int   n_tot  = 0;
  int   n_pass = 0;
  logic [31:0] m_acc;

  e203_nice_macc_if bus();

  e203_nice_macc_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nice        (bus),
    .nice_active (nice_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rdat;
    logic        err;
    int          lat;
  } vec_t;

  function automatic logic [31:0] mk(
    input logic [6:0] f7,
    input logic [6:0] opc
  );
    return {f7, 18'h0, opc};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, got, exp);
  endtask

  // Reference: result/acc from the op rules
  task automatic model(input logic [31:0] ins,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] rd,
                       output logic er,
                       output int lat);
    logic [31:0] p;
    rd = 0; er = 1; lat = 0;
    if (ins[6:0] == OPC) begin
      case (ins[31:25])
        7'h01: begin
          p = a * b;
          m_acc = m_acc + p;
          rd = m_acc; er = 0; lat = 32;
        end
        7'h02: begin rd = m_acc; m_acc = 0; er = 0; end
        7'h03: begin rd = m_acc; m_acc = a; er = 0; end
        7'h04: begin rd = m_acc; er = 0; end
        default: ;
      endcase
    end
  endtask

  // One request, rsp_ready held high; lat counts
  // edges after the accept edge until rsp_valid.
  task automatic do_op(input logic [31:0] ins,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] rd,
                       output logic er,
                       output int lat,
                       output logic rdy_bad);
    bus.nice_req_instr = ins;
    bus.nice_req_rs1   = a;
    bus.nice_req_rs2   = b;
    bus.nice_req_valid = 1'b1;
    lat = 0;
    rdy_bad = 1'b0;
    @(posedge clk); #1;
    bus.nice_req_valid = 1'b0;
    bus.nice_req_instr = $urandom;
    bus.nice_req_rs1   = $urandom;
    bus.nice_req_rs2   = $urandom;
    while (!bus.nice_rsp_valid && lat < 200) begin
      if (bus.nice_req_ready || !nice_active)
        rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.nice_rsp_rdat;
    er = bus.nice_rsp_err;
    if (bus.nice_req_ready) rdy_bad = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_chk(input string nm,
                         input logic [31:0] ins,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] erd,
                         input logic eer,
                         input int elat);
    logic [31:0] rd;
    logic er;
    int lat;
    logic bad;
    do_op(ins, a, b, rd, er, lat, bad);
    chk({nm, "_rdat"}, rd, erd);
    chk({nm, "_err"}, {31'd0, er}, {31'd0, eer});
    chk({nm, "_lat"}, lat, elat);
    if (elat > 0)
      chk({nm, "_busy_rdy"}, {31'd0, bad}, 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [31:0] erd;
    logic eer;
    int elat;
    logic [31:0] hold;
    logic bad;
    int seen;

    tbl[0] = '{mk(7'h03, OPC), 32'h5, 32'h0,
               32'h0, 1'b0, 0};
    tbl[1] = '{mk(7'h04, OPC), 32'h0, 32'h0,
               32'h5, 1'b0, 0};
    tbl[2] = '{mk(7'h01, OPC), 32'h3, 32'h7,
               32'h1A, 1'b0, 32};
    tbl[3] = '{mk(7'h04, OPC), 32'h0, 32'h0,
               32'h1A, 1'b0, 0};
    tbl[4] = '{mk(7'h02, OPC), 32'h0, 32'h0,
               32'h1A, 1'b0, 0};
    tbl[5] = '{mk(7'h01, OPC), 32'hFFFFFFFF, 32'h2,
               32'hFFFFFFFE, 1'b0, 32};
    tbl[6] = '{mk(7'h01, OPC), 32'h1, 32'h2,
               32'h0, 1'b0, 32};
    tbl[7] = '{mk(7'h7F, OPC), 32'h9, 32'h9,
               32'h0, 1'b1, 0};
    tbl[8] = '{mk(7'h01, 7'h0B), 32'h9, 32'h9,
               32'h0, 1'b1, 0};
    tbl[9] = '{mk(7'h04, OPC), 32'h0, 32'h0,
               32'h0, 1'b0, 0};

    rst_n = 1'b0;
    bus.nice_req_valid = 1'b0;
    bus.nice_req_instr = '0;
    bus.nice_req_rs1   = '0;
    bus.nice_req_rs2   = '0;
    bus.nice_rsp_ready = 1'b1;
    m_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.nice_req_ready}, 1);
    chk("rst_rsp_valid", {31'd0, bus.nice_rsp_valid}, 0);
    chk("rst_active", {31'd0, nice_active}, 0);
    chk("rst_rdat", bus.nice_rsp_rdat, 0);
    chk("rst_err", {31'd0, bus.nice_rsp_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, bus.nice_req_ready}, 1);

    // Directed table
    foreach (tbl[i]) begin
      run_chk($sformatf("tbl%0d", i), tbl[i].instr,
              tbl[i].rs1, tbl[i].rs2, tbl[i].rdat,
              tbl[i].err, tbl[i].lat);
      model(tbl[i].instr, tbl[i].rs1, tbl[i].rs2,
            erd, eer, elat);
    end

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins, a, b;
      logic [6:0] f7, opc;
      f7  = 7'($urandom_range(1, 5));
      if (f7 == 7'd5) f7 = 7'($urandom);
      opc = ($urandom_range(0, 7) == 0) ?
            7'($urandom) : OPC;
      ins = {f7, 18'($urandom), opc};
      a = $urandom;
      b = $urandom;
      model(ins, a, b, erd, eer, elat);
      run_chk($sformatf("rnd%0d", i), ins, a, b,
              erd, eer, elat);
    end

    // Backpressure on an RDACC response
    model(mk(7'h03, OPC), 32'hA5A5_1234, 0,
          erd, eer, elat);
    run_chk("bp_set", mk(7'h03, OPC), 32'hA5A5_1234, 0,
            erd, eer, elat);
    bus.nice_rsp_ready = 1'b0;
    bus.nice_req_instr = mk(7'h04, OPC);
    bus.nice_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.nice_req_valid = 1'b0;
    hold = bus.nice_rsp_rdat;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!bus.nice_rsp_valid || bus.nice_req_ready ||
          bus.nice_rsp_rdat !== hold)
        bad = 1'b1;
      bus.nice_req_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_rdat", hold, 32'hA5A5_1234);
    chk("bp_stable", {31'd0, bad}, 0);
    chk("bp_valid", {31'd0, bus.nice_rsp_valid}, 1);
    bus.nice_req_valid = 1'b0;
    bus.nice_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after", {31'd0, bus.nice_req_ready}, 1);
    chk("bp_valid_drop", {31'd0, bus.nice_rsp_valid}, 0);

    // Reset in the middle of a MACC
    bus.nice_req_instr = mk(7'h01, OPC);
    bus.nice_req_rs1   = 32'd11;
    bus.nice_req_rs2   = 32'd13;
    bus.nice_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.nice_req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_active", {31'd0, nice_active}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, bus.nice_req_ready}, 1);
    chk("arst_active", {31'd0, nice_active}, 0);
    chk("arst_rdat", bus.nice_rsp_rdat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.nice_rsp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("arst_no_rsp", seen, 0);
    chk("arst_ready2", {31'd0, bus.nice_req_ready}, 1);
    run_chk("arst_rd", mk(7'h04, OPC), 0, 0, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/e203_nice_macc_core.md
# e203_nice_macc_core

Single-outstanding NICE coprocessor core on the downstream side of the E203 NICE request/response channel. It accepts custom-3 instructions (with rs1/rs2 operands) over the NICE request handshake and keeps a 32-bit accumulator. It runs a multi-cycle shift-add multiply-accumulate, or single-cycle accumulator ops, and returns one in-order response per accepted request. That response drives the core-side multi-cycle response handshake, which pops the NICE itag FIFO.

## Interface
- OPCODE, 7'b1111011, instr[6:0] value treated as a legal instruction (custom-3)
- MUL_CYCLES, 32, shift-add iterations per MACC; fixed, one multiplier bit per cycle
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low (one clock, async active-low reset: already decided)
- nice_req_valid  in  1  request valid
- nice_req_ready  out  1  request ready; equals (state == IDLE)
- nice_req_instr  in  32  instruction word
- nice_req_rs1  in  32  operand 1
- nice_req_rs2  in  32  operand 2
- nice_rsp_valid  out  1  response valid; connects to the multi-cycle response-valid input of the NICE stage
- nice_rsp_ready  in  1  response ready from the NICE stage
- nice_rsp_rdat  out  32  result data
- nice_rsp_err  out  1  illegal-instruction flag, qualified by nice_rsp_valid
- nice_active  out  1  (state != IDLE); clock-gate/idle hint

## Operation
- Request accept: nice_req_valid & nice_req_ready at a rising edge. Instr, rs1 and rs2 are captured in that cycle; the inputs are don't-care afterwards.
- Decode: the instruction is illegal if instr[6:0] != OPCODE. Otherwise the op is selected by f7 = instr[31:25].
  - f7 0x01 MACC: acc <= acc + low32(rs1*rs2); rdat = new acc. Multi-cycle.
  - f7 0x02 CLRACC: acc <= 0; rdat = old acc.
  - f7 0x03 SETACC: acc <= rs1; rdat = old acc.
  - f7 0x04 RDACC: rdat = acc; acc unchanged.
  - Any other f7, or a bad opcode: err = 1, rdat = 0, acc unchanged.
- FSM states: IDLE, BUSY, RSP.
  - IDLE: on accept, MACC goes to BUSY; every other op (including illegal) goes to RSP, with rdat, err and acc updated at the accept edge.
  - BUSY: iteration counter cnt counts 0..MUL_CYCLES-1. Each cycle: if mplr[0], prod += mcand; then mcand <<= 1 and mplr >>= 1, all modulo 2^32. On the edge where cnt == MUL_CYCLES-1: acc <= acc + prod_final (mod 2^32), rdat <= the same value, next state RSP.
  - RSP: nice_rsp_valid = 1. On nice_rsp_valid & nice_rsp_ready, go to IDLE.
- Arithmetic: only the low 32 bits are kept, so the result is identical for signed and unsigned operands. Carries out of bit 31 are dropped silently.
- At most one request is outstanding. Responses are therefore strictly in order, matching the itag FIFO ordering upstream.
- nice_rsp_rdat and nice_rsp_err hold stable from rsp_valid rise until the handshake completes.

## Timing
- Reset values: state IDLE, acc 0, prod/mcand/mplr/cnt 0, nice_rsp_valid 0, nice_rsp_rdat 0, nice_rsp_err 0, nice_active 0.
- nice_req_ready is 1 while in reset and immediately after reset.
- Single-cycle op accepted at edge T: nice_rsp_valid is high from T+1.
- MACC accepted at edge T: nice_rsp_valid is high from T+1+MUL_CYCLES, i.e. T+33 by default.
- With nice_rsp_ready tied high, back-to-back single-cycle ops sustain 1 request per 2 cycles. nice_req_ready rises the cycle after the response handshake; there is no combinational path from rsp_ready to req_ready.
- A request is never accepted in the same cycle as a response handshake.
- No combinational paths from any input to nice_rsp_valid, nice_rsp_rdat or nice_rsp_err; all are registered.
- nice_req_ready depends only on state.
- Reset asserted mid-BUSY or mid-RSP: the operation is aborted, no response is issued, acc returns to 0, and all outputs take their reset values asynchronously.
- Response backpressure of unbounded length is legal. The FSM stays in RSP with outputs frozen.

## Test plan
- Reset, then SETACC (f7=0x03, rs1=0x5): rsp_valid at T+1 with rdat=0, err=0. Follow with RDACC: rdat=0x5.
- acc=5, then MACC with rs1=3, rs2=7: req_ready=0 for 33 cycles, rsp_valid at T+33, rdat=26 (0x1A). A following RDACC returns 0x1A.
- acc=0, then MACC with rs1=0xFFFFFFFF, rs2=2: rdat=0xFFFFFFFE. Then MACC with rs1=1, rs2=2: rdat=0x00000000 (wrap-around).
- Hold rsp_ready=0 for 10 cycles during an RDACC response: rsp_valid stays 1, rdat is stable, req_ready stays 0. Release rsp_ready: handshake completes, and req_ready=1 on the next cycle.
- Send f7=0x7F, then opcode 0x0B with f7=0x01: each gives rsp_valid at T+1 with err=1, rdat=0, and acc unchanged (checked by a following RDACC).
- Assert rst_n=0 at cycle 10 of a MACC: rsp_valid never asserts for that MACC, req_ready=1 after reset, and RDACC returns 0.
